ring_count_readout: RTL and testbench
=====================================

Name: ring_count_readout

Overview:
- Downstream stage of the time-domain register ring oscillator.
- Drives the oscillator's control inputs: tsc (enable window), carry_b (overflow stop) and RE (read-enable freeze).
- Synchronises the free-running ring output into the system clock domain and counts its rising edges over a programmable window.
- Presents the frozen count to the readout bus through a valid/ready handshake.

Parameters:
- COUNT_W, 12: edge-counter width; saturates at 2^COUNT_W-1.
- WINDOW_W, 16: width of the measurement-window length input, in clk cycles.
- SYNC_STAGES, 2: flops in the ring_i synchroniser; minimum 2.
- DRAIN_CYC, 3: clk cycles spent counting in-flight edges after tsc_o falls; must be >= SYNC_STAGES+1.

Ports:
- clk  input  1  system clock; only clock in the block.
- rstb  input  1  asynchronous, active-low reset.
- start_i  input  1  single-cycle request to begin a measurement; ignored unless state is IDLE.
- window_i  input  WINDOW_W  measurement length in clk cycles; sampled on start acceptance.
- ring_i  input  1  ring oscillator output; asynchronous to clk.
- tsc_o  output  1  oscillator enable; feeds the oscillator tsc input.
- carry_b_o  output  1  active-low overflow stop; feeds the oscillator carry_b input.
- re_o  output  1  read-enable freeze; feeds the oscillator RE input.
- count_o  output  COUNT_W  captured edge count.
- ovf_o  output  1  counter saturated during this measurement.
- valid_o  output  1  count_o/ovf_o valid.
- ready_i  input  1  consumer accepts the result.
- busy_o  output  1  high in any state other than IDLE.

Behaviour:
- Reset values (asynchronous assertion): tsc_o=0, carry_b_o=1, re_o=0, count_o=0, ovf_o=0, valid_o=0, busy_o=0, state=IDLE, synchroniser flops=0.
- Reset release is synchronous to clk.
- Reset mid-operation aborts immediately; any pending result is lost.
- Synchroniser: ring_i passes through SYNC_STAGES flops, plus one history flop.
- Edge detect: edge = sync_last & ~hist.
- Requirement on the oscillator: ring frequency < clk/2. Faster rings alias, and the block does not detect this.
- State machine:
  - IDLE: outputs low/inactive, carry_b_o=1.
    - On start_i: clear count and ovf, load win_cnt=window_i, go to RUN on the next edge.
    - If window_i==0: go straight to DRAIN, tsc_o never rises, final count 0.
  - RUN: tsc_o=1. Decrement win_cnt each cycle and count edges. When win_cnt==1, the next state is DRAIN. tsc_o is high for exactly window_i cycles.
  - DRAIN: tsc_o=0. Count edges for DRAIN_CYC cycles to flush the synchroniser, then go to READ.
  - READ: re_o=1, valid_o=1, count_o/ovf_o stable.
    - On valid_o & ready_i in the same cycle: go to IDLE. valid_o and re_o drop the next cycle.
    - valid_o holds until accepted; there is no timeout.
- Counter saturation:
  - count increments by 1 per edge until it equals 2^COUNT_W-1.
  - On the cycle the count reaches max, ovf_o is set and carry_b_o goes to 0 the following cycle, stopping the ring.
  - Further edges are ignored.
  - carry_b_o returns to 1 only on return to IDLE.
- start_i while busy: ignored, with no effect on the window or count.
- start_i asserted in the same cycle READ is accepted: ignored (IDLE is not yet entered).
- busy_o=1 in RUN, DRAIN and READ.
- count_o updates only while not in READ. count_o is held from entry to READ until the next start acceptance.

Test Plan:
- Nominal run:
  - Stimulus: clk 100 MHz, ring 12.5 MHz, window_i=80, ready_i=1.
  - Required: tsc_o high exactly 80 cycles; count_o=10±1; ovf_o=0; valid_o pulses 1 cycle; re_o high during READ only.
- Back-pressure:
  - Stimulus: same run with ready_i=0 for 20 cycles after valid_o rises.
  - Required: valid_o, re_o and count_o stay constant for those 20 cycles; IDLE is entered one cycle after ready_i=1.
- Saturation:
  - Stimulus: COUNT_W=4, ring 25 MHz, window_i=200.
  - Required: count_o=15; ovf_o=1; carry_b_o=0 from the cycle after the count hits 15 until IDLE; no wrap to 0.
- Zero window:
  - Stimulus: window_i=0, start_i pulse, ring toggling.
  - Required: tsc_o never asserts; count_o=0; valid_o asserts after DRAIN_CYC cycles.
- Start while busy:
  - Stimulus: start_i pulsed in RUN with window_i=5, after an original window_i=50.
  - Required: tsc_o high 50 cycles; a single result is produced.
- Async reset mid-RUN:
  - Stimulus: rstb low for 1 ns, asynchronous to clk, during RUN.
  - Required: tsc_o=0, carry_b_o=1, re_o=0, valid_o=0, count_o=0 immediately, without waiting for a clk edge; a new start_i after release runs normally.

Source files
------------

// File: rtl/ring_count_readout.sv
`timescale 1ns / 1ps
// Readout stage for the register ring oscillator: gates the ring, counts its synchronised
// rising edges over a programmable window and hands the frozen count over valid/ready.
module ring_count_readout #(
  parameter int unsigned COUNT_W     = 12,
  parameter int unsigned WINDOW_W    = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DRAIN_CYC   = 3
) (
  input  logic                clk,
  input  logic                rstb,
  input  logic                start_i,
  input  logic [WINDOW_W-1:0] window_i,
  input  logic                ring_i,
  output logic                tsc_o,
  output logic                carry_b_o,
  output logic                re_o,
  output logic [COUNT_W-1:0]  count_o,
  output logic                ovf_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StRead} state_e;

  localparam logic [COUNT_W-1:0]  CountMax  = '1;
  localparam logic [WINDOW_W-1:0] DrainLoad = WINDOW_W'(DRAIN_CYC);

  state_e               state_q, state_d;
  logic [WINDOW_W-1:0]  win_q, win_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 carry_b_q, carry_b_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                 hist_q;
  logic                 ring_edge;
  logic                 counting;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ring_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign ring_edge = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign counting  = (state_q == StRun) || (state_q == StDrain);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q   <= StIdle;
      win_q     <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      carry_b_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      win_q     <= win_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      carry_b_q <= carry_b_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    carry_b_d = carry_b_q;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          count_d = '0;
          ovf_d   = 1'b0;
          // A zero window skips RUN entirely so tsc_o never pulses.
          if (window_i == '0) begin
            win_d   = DrainLoad;
            state_d = StDrain;
          end else begin
            win_d   = window_i;
            state_d = StRun;
          end
        end
      end
      StRun: begin
        win_d = win_q - WINDOW_W'(1);
        if (win_q == WINDOW_W'(1)) begin
          win_d   = DrainLoad;
          state_d = StDrain;
        end
      end
      StDrain: begin
        win_d = win_q - WINDOW_W'(1);
        if (win_q == WINDOW_W'(1)) state_d = StRead;
      end
      StRead: begin
        if (ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (counting && ring_edge && (count_q != CountMax)) begin
      count_d = count_q + COUNT_W'(1);
      if (count_q == CountMax - COUNT_W'(1)) ovf_d = 1'b1;
    end

    // Stop the ring one cycle after saturation; release only when back in IDLE.
    if (state_d == StIdle) begin
      carry_b_d = 1'b1;
    end else if (ovf_q && (state_q != StIdle)) begin
      carry_b_d = 1'b0;
    end
  end

  assign tsc_o     = (state_q == StRun);
  assign re_o      = (state_q == StRead);
  assign valid_o   = (state_q == StRead);
  assign busy_o    = (state_q != StIdle);
  assign count_o   = count_q;
  assign ovf_o     = ovf_q;
  assign carry_b_o = carry_b_q;

endmodule

// File: tb/tb_ring_count_readout.sv
`timescale 1ns / 1ps
// Bench for ring_count_readout: behavioural gated ring oscillator plus a result scoreboard.
module tb_ring_count_readout;

  localparam int unsigned COUNT_W     = 4;
  localparam int unsigned WINDOW_W    = 16;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned DRAIN_CYC   = 3;
  localparam int          CountMax    = (1 << COUNT_W) - 1;
  localparam int          ClkPeriod   = 10;

  logic                clk = 1'b0;
  logic                rstb;
  logic                start_i;
  logic [WINDOW_W-1:0] window_i;
  logic                ring_i;
  logic                tsc_o;
  logic                carry_b_o;
  logic                re_o;
  logic [COUNT_W-1:0]  count_o;
  logic                ovf_o;
  logic                valid_o;
  logic                ready_i;
  logic                busy_o;

  typedef struct {
    int   exp_count;
    int   tol;
    logic exp_ovf;
  } result_t;

  result_t sb_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int ring_half = 40;

  always #(ClkPeriod / 2) clk = ~clk;

  ring_count_readout #(
    .COUNT_W    (COUNT_W),
    .WINDOW_W   (WINDOW_W),
    .SYNC_STAGES(SYNC_STAGES),
    .DRAIN_CYC  (DRAIN_CYC)
  ) dut (
    .clk      (clk),
    .rstb     (rstb),
    .start_i  (start_i),
    .window_i (window_i),
    .ring_i   (ring_i),
    .tsc_o    (tsc_o),
    .carry_b_o(carry_b_o),
    .re_o     (re_o),
    .count_o  (count_o),
    .ovf_o    (ovf_o),
    .valid_o  (valid_o),
    .ready_i  (ready_i),
    .busy_o   (busy_o)
  );

  // Oscillator runs only while enabled and not stopped, with a phase offset from clk.
  initial begin
    ring_i = 1'b0;
    forever begin
      wait (tsc_o === 1'b1 && carry_b_o === 1'b1);
      #3;
      while (tsc_o === 1'b1 && carry_b_o === 1'b1) begin
        ring_i = ~ring_i;
        #(ring_half);
      end
      ring_i = 1'b0;
    end
  end

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded 200us time limit");
    $fatal(1, "watchdog");
  end

  task automatic push_expect(input int window);
    result_t r;
    int edges;
    edges = (window * ClkPeriod + 2 * ring_half - 1) / (2 * ring_half);
    r.exp_ovf   = (edges >= CountMax);
    r.exp_count = r.exp_ovf ? CountMax : edges;
    r.tol       = (r.exp_ovf || window == 0) ? 0 : 1;
    sb_q.push_back(r);
  endtask

  // Caller is at a negedge; start is seen by the next posedge.
  task automatic do_start(input int window, input bit expect_result);
    start_i  = 1'b1;
    window_i = WINDOW_W'(window);
    if (expect_result) push_expect(window);
    @(posedge clk);
    #1 start_i = 1'b0;
  endtask

  // cyc = posedges after the accepting edge until valid_o is seen, -1 on timeout.
  task automatic run_until_valid(input int budget, output int cyc, output int tsc_hi,
                                 output int re_bad);
    cyc = -1;
    tsc_hi = 0;
    re_bad = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (tsc_o === 1'b1) tsc_hi++;
      if (re_o !== valid_o) re_bad++;
      if (valid_o === 1'b1) begin
        cyc = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0; start_i = 1'b0; ready_i = 1'b1; window_i = '0;
    #12;
    n_checks++;
    if ({tsc_o, carry_b_o, re_o, ovf_o, valid_o, busy_o} !== 6'b010000)
      $display("FAIL reset_ctrl: got %b want 010000",
               {tsc_o, carry_b_o, re_o, ovf_o, valid_o, busy_o});
    else n_pass++;
    n_checks++;
    if (count_o !== '0) $display("FAIL reset_count: got %0d want 0", count_o);
    else n_pass++;
    @(negedge clk); rstb = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy_o, valid_o, carry_b_o} !== 3'b001)
      $display("FAIL reset_idle: got %b want 001", {busy_o, valid_o, carry_b_o});
    else n_pass++;
  endtask

  task automatic test_nominal();
    int cyc, tsc_hi, re_bad, diff;
    logic [COUNT_W-1:0] held;
    result_t r;
    ring_half = 40; ready_i = 1'b1;
    @(negedge clk); do_start(80, 1'b1);
    run_until_valid(400, cyc, tsc_hi, re_bad);
    n_checks++;
    if (cyc < 0) $display("FAIL nominal_timeout: valid_o absent after 400 cycles");
    else n_pass++;
    r = sb_q.pop_front();
    diff = int'(count_o) - r.exp_count;
    n_checks++;
    if (diff > r.tol || diff < -r.tol)
      $display("FAIL nominal_count: got %0d want %0d+-%0d", count_o, r.exp_count, r.tol);
    else n_pass++;
    n_checks++;
    if (ovf_o !== r.exp_ovf) $display("FAIL nominal_ovf: got %b want %b", ovf_o, r.exp_ovf);
    else n_pass++;
    n_checks++;
    if (tsc_hi != 80) $display("FAIL nominal_tsc_len: got %0d want 80", tsc_hi);
    else n_pass++;
    n_checks++;
    if (re_bad != 0) $display("FAIL nominal_re_track: re_o differed from valid_o %0d times", re_bad);
    else n_pass++;
    held = count_o;
    @(negedge clk);
    n_checks++;
    if ({valid_o, re_o, busy_o} !== 3'b000)
      $display("FAIL nominal_valid_pulse: got %b want 000", {valid_o, re_o, busy_o});
    else n_pass++;
    n_checks++;
    if (count_o !== held) $display("FAIL nominal_idle_hold: got %0d want %0d", count_o, held);
    else n_pass++;
  endtask

  task automatic test_back_pressure();
    int cyc, tsc_hi, re_bad, diff, unstable;
    logic [COUNT_W+1:0] held;
    result_t r;
    ring_half = 40; ready_i = 1'b0;
    @(negedge clk); do_start(80, 1'b1);
    run_until_valid(400, cyc, tsc_hi, re_bad);
    n_checks++;
    if (cyc < 0) $display("FAIL bp_timeout: valid_o absent after 400 cycles");
    else n_pass++;
    r = sb_q.pop_front();
    diff = int'(count_o) - r.exp_count;
    n_checks++;
    if (diff > r.tol || diff < -r.tol)
      $display("FAIL bp_count: got %0d want %0d+-%0d", count_o, r.exp_count, r.tol);
    else n_pass++;
    held = {valid_o, re_o, count_o};
    unstable = 0;
    repeat (20) begin
      @(negedge clk);
      if ({valid_o, re_o, count_o} !== held) unstable++;
    end
    n_checks++;
    if (unstable != 0 || held[COUNT_W+1:COUNT_W] !== 2'b11)
      $display("FAIL bp_hold: %0d unstable cycles, valid/re %b want 11", unstable,
               held[COUNT_W+1:COUNT_W]);
    else n_pass++;
    ready_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy_o, valid_o, re_o} !== 3'b000)
      $display("FAIL bp_release: got %b want 000", {busy_o, valid_o, re_o});
    else n_pass++;
  endtask

  task automatic test_saturation();
    int cyc, hit, pre_bad, carry_bad, wrap_bad;
    int prev;
    logic ovf_at_hit, carry_at_hit;
    result_t r;
    ring_half = 20; ready_i = 1'b1;
    cyc = -1; hit = -1; pre_bad = 0; carry_bad = 0; wrap_bad = 0; prev = 0;
    ovf_at_hit = 1'b0; carry_at_hit = 1'b0;
    @(negedge clk); do_start(200, 1'b1);
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (int'(count_o) < prev) wrap_bad++;
      prev = int'(count_o);
      if (hit < 0 && int'(count_o) == CountMax) begin
        hit = i; ovf_at_hit = ovf_o; carry_at_hit = carry_b_o;
      end else if (hit >= 0 && busy_o === 1'b1) begin
        if (carry_b_o !== 1'b0) carry_bad++;
      end else if (hit < 0) begin
        if (ovf_o !== 1'b0 || carry_b_o !== 1'b1) pre_bad++;
      end
      if (valid_o === 1'b1) begin
        cyc = i;
        break;
      end
    end
    n_checks++;
    if (cyc < 0 || hit < 0) $display("FAIL sat_progress: valid at %0d, max hit at %0d", cyc, hit);
    else n_pass++;
    r = sb_q.pop_front();
    n_checks++;
    if (int'(count_o) != r.exp_count || ovf_o !== r.exp_ovf)
      $display("FAIL sat_result: got %0d/%b want %0d/%b", count_o, ovf_o, r.exp_count, r.exp_ovf);
    else n_pass++;
    n_checks++;
    if (ovf_at_hit !== 1'b1 || carry_at_hit !== 1'b1)
      $display("FAIL sat_at_max: ovf/carry_b %b%b want 11", ovf_at_hit, carry_at_hit);
    else n_pass++;
    n_checks++;
    if (carry_bad != 0 || pre_bad != 0)
      $display("FAIL sat_carry_b: %0d late-high, %0d early-stop cycles, want 0", carry_bad, pre_bad);
    else n_pass++;
    n_checks++;
    if (wrap_bad != 0) $display("FAIL sat_wrap: count decreased %0d times, want 0", wrap_bad);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({busy_o, carry_b_o} !== 2'b01)
      $display("FAIL sat_idle_carry: busy/carry_b %b want 01", {busy_o, carry_b_o});
    else n_pass++;
  endtask

  task automatic test_zero_window();
    int cyc, tsc_hi, re_bad;
    result_t r;
    ring_half = 40; ready_i = 1'b1;
    @(negedge clk); do_start(0, 1'b1);
    run_until_valid(50, cyc, tsc_hi, re_bad);
    n_checks++;
    if (cyc != int'(DRAIN_CYC)) $display("FAIL zero_latency: got %0d want %0d", cyc, DRAIN_CYC);
    else n_pass++;
    n_checks++;
    if (tsc_hi != 0) $display("FAIL zero_tsc: tsc_o high %0d cycles want 0", tsc_hi);
    else n_pass++;
    r = sb_q.pop_front();
    n_checks++;
    if (int'(count_o) != r.exp_count || ovf_o !== r.exp_ovf)
      $display("FAIL zero_result: got %0d/%b want %0d/%b", count_o, ovf_o, r.exp_count, r.exp_ovf);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int cyc, tsc_hi, t2, re_bad, diff, extra_valid, extra_busy;
    result_t r;
    ring_half = 40; ready_i = 1'b1;
    @(negedge clk); do_start(50, 1'b1);
    tsc_hi = 0;
    repeat (10) begin
      @(negedge clk);
      if (tsc_o === 1'b1) tsc_hi++;
    end
    do_start(5, 1'b0);
    run_until_valid(300, cyc, t2, re_bad);
    n_checks++;
    if (cyc < 0) $display("FAIL busy_timeout: valid_o absent after 300 cycles");
    else n_pass++;
    n_checks++;
    if (tsc_hi + t2 != 50) $display("FAIL busy_tsc_len: got %0d want 50", tsc_hi + t2);
    else n_pass++;
    r = sb_q.pop_front();
    diff = int'(count_o) - r.exp_count;
    n_checks++;
    if (diff > r.tol || diff < -r.tol)
      $display("FAIL busy_count: got %0d want %0d+-%0d", count_o, r.exp_count, r.tol);
    else n_pass++;
    extra_valid = 0; extra_busy = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid_o !== 1'b0) extra_valid++;
      if (busy_o !== 1'b0) extra_busy++;
    end
    n_checks++;
    if (extra_valid != 0 || extra_busy != 0)
      $display("FAIL busy_single: %0d extra valid, %0d busy cycles, want 0", extra_valid,
               extra_busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    int cyc, tsc_hi, re_bad, diff;
    result_t r;
    ring_half = 40; ready_i = 1'b1;
    @(negedge clk); do_start(80, 1'b1);
    repeat (40) @(negedge clk);
    n_checks++;
    if (tsc_o !== 1'b1 || count_o == '0)
      $display("FAIL arst_pre: tsc/count %b/%0d want 1/nonzero", tsc_o, count_o);
    else n_pass++;
    @(posedge clk);
    #3 rstb = 1'b0;
    #0.5;
    n_checks++;
    if ({tsc_o, carry_b_o, re_o, valid_o, busy_o} !== 5'b01000)
      $display("FAIL arst_ctrl: got %b want 01000", {tsc_o, carry_b_o, re_o, valid_o, busy_o});
    else n_pass++;
    n_checks++;
    if (count_o !== '0) $display("FAIL arst_count: got %0d want 0", count_o);
    else n_pass++;
    #0.5 rstb = 1'b1;
    sb_q.delete();
    repeat (6) @(negedge clk);
    n_checks++;
    if ({busy_o, valid_o} !== 2'b00) $display("FAIL arst_idle: got %b want 00", {busy_o, valid_o});
    else n_pass++;
    do_start(40, 1'b1);
    run_until_valid(300, cyc, tsc_hi, re_bad);
    n_checks++;
    if (cyc < 0 || tsc_hi != 40)
      $display("FAIL arst_rerun: valid at %0d, tsc high %0d want 40", cyc, tsc_hi);
    else n_pass++;
    r = sb_q.pop_front();
    diff = int'(count_o) - r.exp_count;
    n_checks++;
    if (diff > r.tol || diff < -r.tol || ovf_o !== r.exp_ovf)
      $display("FAIL arst_count2: got %0d/%b want %0d+-%0d/%b", count_o, ovf_o, r.exp_count,
               r.tol, r.exp_ovf);
    else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_back_pressure();
    test_saturation();
    test_zero_window();
    test_start_while_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
